reg_readback_serializer: RTL and testbench

//  Debug/observation port for the MCU register bank: on a start request it reads

---
 rtl/reg_readback_serializer_if.sv | 30 +++
 rtl/reg_readback_serializer.sv | 153 +++++++++++++++
 tb/tb_reg_readback_serializer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_readback_serializer_if.sv
// Readback serializer bus: request/status, bank read port
// and the 3-wire serial link.
interface reg_readback_serializer_if #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [BUS_WIDTH-1:0]  reg_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  sclk;
  logic                  sdata;
  logic                  sframe;

  modport master (
    output start, start_addr, count, reg_data,
    input  reg_addr, busy, done, err,
    input  sclk, sdata, sframe
  );

  modport slave (
    input  start, start_addr, count, reg_data,
    output reg_addr, busy, done, err,
    output sclk, sdata, sframe
  );
endinterface

// File: rtl/reg_readback_serializer.sv
// Reads COUNT consecutive bank registers and shifts them
// out MSB-first on sclk/sdata inside one sframe.
module reg_readback_serializer #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int CLK_DIV    = 2
) (
  input logic                     clk,
  input logic                     rst,
  reg_readback_serializer_if.slave bus
);
  localparam int BCW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int PCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW  = ADDR_WIDTH + 1;
  localparam logic [BCW-1:0] BTOP = BCW'(BUS_WIDTH - 1);
  localparam logic [PCW-1:0] PTOP = PCW'(CLK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE, FETCH, SHIFT, FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [BUS_WIDTH-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic [PCW-1:0]        ph_q, ph_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic sclk_q, sclk_d;
  logic sdata_q, sdata_d;
  logic sframe_q, sframe_d;
  logic bad_req;

  assign bad_req =
    (32'(bus.start_addr) >= 32'(NUM_REGS)) ||
    (32'(bus.count) > 32'(NUM_REGS));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    sframe_d = sframe_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bad_req) begin
            state_d = FINISH;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (bus.count == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            addr_d  = bus.start_addr;
            rem_d   = bus.count;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        shreg_d  = bus.reg_data;
        sdata_d  = bus.reg_data[BUS_WIDTH-1];
        sframe_d = 1'b1;
        sclk_d   = 1'b0;
        bit_d    = BTOP;
        ph_d     = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (ph_q != PTOP) begin
          ph_d = ph_q + PCW'(1);
        end else begin
          ph_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q != '0) begin
              bit_d   = bit_q - BCW'(1);
              shreg_d = shreg_q << 1;
              sdata_d = shreg_d[BUS_WIDTH-1];
            end else if (rem_q > CW'(1)) begin
              // next register rides in the same frame
              rem_d   = rem_q - CW'(1);
              addr_d  = (addr_q == LAST) ? '0
                      : addr_q + ADDR_WIDTH'(1);
              state_d = FETCH;
            end else begin
              state_d = FINISH;
              done_d  = 1'b1;
            end
          end
        end
      end
      FINISH: begin
        sframe_d = 1'b0;
        sdata_d  = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      shreg_q  <= '0;
      bit_q    <= '0;
      ph_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sframe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      sframe_q <= sframe_d;
    end
  end

  assign bus.reg_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.sclk     = sclk_q;
  assign bus.sdata    = sdata_q;
  assign bus.sframe   = sframe_q;
endmodule

// File: tb/tb_reg_readback_serializer.sv
// Bench for reg_readback_serializer: directed scenarios
// plus random requests against a byte-stream model.
module tb_reg_readback_serializer;
  localparam int BW = 8;
  localparam int NR = 4;
  localparam int AW = 2;
  localparam int CD = 2;
  localparam int PER_REG = 1 + 2 * CD * BW;
  localparam int LIMIT = PER_REG * NR + 10;

  logic clk;
  logic rst;
  logic [7:0] bank [NR];

  int n_asserts = 0;
  int n_fail = 0;

  logic [31:0] cap_bits;
  int cap_n, frame_cyc, done_n, done_cyc;
  int addr_n, err_stray;
  logic err_seen, sclk_act;
  logic rs_sclk, rs_sframe, rs_busy;
  logic [1:0] addr_seq [4];

  reg_readback_serializer_if #(
    .BUS_WIDTH(BW), .ADDR_WIDTH(AW)
  ) bus ();

  assign bus.reg_data = bank[bus.reg_addr];

  reg_readback_serializer #(
    .BUS_WIDTH(BW), .NUM_REGS(NR),
    .ADDR_WIDTH(AW), .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // expected serial stream: requested bytes back to back
  function automatic logic [31:0] model_stream(
    input int a, input int n);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = (s << 8) | 32'(bank[(a + i) % NR]);
    return s;
  endfunction

  task automatic run_xfer(
    input logic [1:0] a, input logic [2:0] n,
    input int inj_start, input int inj_wr,
    input int inj_rst);
    logic prev;
    prev = 1'b0;
    cap_bits = '0; cap_n = 0; frame_cyc = 0;
    done_n = 0; done_cyc = -1; addr_n = 0;
    err_stray = 0; err_seen = 1'b0; sclk_act = 1'b0;
    rs_sclk = 1'b1; rs_sframe = 1'b1; rs_busy = 1'b1;
    @(posedge clk);
    bus.start_addr = a;
    bus.count = n;
    bus.start = 1'b1;
    for (int c = 1; c <= LIMIT; c++) begin
      @(posedge clk);
      if (bus.sframe) frame_cyc++;
      if (bus.sclk) sclk_act = 1'b1;
      if (bus.sclk && !prev) begin
        if (cap_n % BW == 0 && addr_n < 4) begin
          addr_seq[addr_n] = bus.reg_addr;
          addr_n++;
        end
        cap_bits = {cap_bits[30:0], bus.sdata};
        cap_n++;
      end
      prev = bus.sclk;
      if (bus.err && !bus.done) err_stray++;
      if (bus.done) begin
        done_n++;
        err_seen = bus.err;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_n > 0 && c >= done_cyc + 2) break;
      bus.start = (c == inj_start);
      if (c == inj_start) begin
        bus.start_addr = 2'd0;
        bus.count = 3'd4;
      end
      if (c == inj_wr) bank[1] = ~bank[1];
      if (c == inj_rst) begin
        rst = 1'b0;
        #1;
        rs_sclk = bus.sclk;
        rs_sframe = bus.sframe;
        rs_busy = bus.busy;
      end
    end
    bus.start = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    int dn;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    outs = {bus.reg_addr, bus.busy, bus.done, bus.err,
            bus.sclk, bus.sdata, bus.sframe};
    n_asserts++;
    if (outs !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0", outs);
    end
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      if (bus.done || bus.busy) dn++;
    end
    n_asserts++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d want 0", dn);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < NR; i++) bank[i] = 8'($urandom);
    bank[2] = 8'hA5;
    run_xfer(2'd2, 3'd1, -1, -1, -1);
    n_asserts++;
    if (cap_bits !== 32'h0000_00A5 || cap_n !== 8) begin
      n_fail++;
      $display("FAIL single_bits: got %h/%0d want a5/8",
               cap_bits, cap_n);
    end
    n_asserts++;
    if (addr_seq[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL single_addr: got %0d want 2",
               addr_seq[0]);
    end
    n_asserts++;
    if (frame_cyc !== 33) begin
      n_fail++;
      $display("FAIL single_frame: got %0d want 33",
               frame_cyc);
    end
    n_asserts++;
    if (done_n !== 1 || done_cyc !== 34 || err_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got %0d@%0d e%b want 1@34 e0",
               done_n, done_cyc, err_seen);
    end
    n_asserts++;
    if (bus.busy !== 1'b0 || err_stray !== 0) begin
      n_fail++;
      $display("FAIL single_idle: got b%b s%0d want b0 s0",
               bus.busy, err_stray);
    end
  endtask

  task automatic test_wrap();
    bank[0] = 8'h11; bank[1] = 8'h22;
    bank[2] = 8'h33; bank[3] = 8'h44;
    run_xfer(2'd3, 3'd3, -1, -1, -1);
    n_asserts++;
    if (cap_bits !== 32'h0044_1122 || cap_n !== 24) begin
      n_fail++;
      $display("FAIL wrap_bits: got %h/%0d want 441122/24",
               cap_bits, cap_n);
    end
    n_asserts++;
    if (addr_n !== 3 || addr_seq[0] !== 2'd3 ||
        addr_seq[1] !== 2'd0 || addr_seq[2] !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_addr: got %0d %0d %0d want 3 0 1",
               addr_seq[0], addr_seq[1], addr_seq[2]);
    end
    n_asserts++;
    if (frame_cyc !== 99 || done_n !== 1 || done_cyc !== 100) begin
      n_fail++;
      $display("FAIL wrap_frame: got f%0d d%0d@%0d want 99 1@100",
               frame_cyc, done_n, done_cyc);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] exp;
    for (int i = 0; i < NR; i++) bank[i] = 8'($urandom);
    exp = model_stream(0, 3);
    run_xfer(2'd0, 3'd3, 10, 45, -1);
    n_asserts++;
    if (cap_bits !== exp || cap_n !== 24) begin
      n_fail++;
      $display("FAIL busy_bits: got %h/%0d want %h/24",
               cap_bits, cap_n, exp);
    end
    n_asserts++;
    if (done_n !== 1 || done_cyc !== 100 || frame_cyc !== 99) begin
      n_fail++;
      $display("FAIL busy_done: got %0d@%0d f%0d want 1@100 f99",
               done_n, done_cyc, frame_cyc);
    end
    repeat (4) @(posedge clk);
    n_asserts++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_queued: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_zero_and_err();
    run_xfer(2'd1, 3'd0, -1, -1, -1);
    n_asserts++;
    if (done_n !== 1 || done_cyc !== 1 || err_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got %0d@%0d e%b want 1@1 e0",
               done_n, done_cyc, err_seen);
    end
    n_asserts++;
    if (sclk_act !== 1'b0 || frame_cyc !== 0) begin
      n_fail++;
      $display("FAIL zero_quiet: got s%b f%0d want 0 0",
               sclk_act, frame_cyc);
    end
    run_xfer(2'd0, 3'd5, -1, -1, -1);
    n_asserts++;
    if (done_n !== 1 || done_cyc !== 1 || err_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL err_done: got %0d@%0d e%b want 1@1 e1",
               done_n, done_cyc, err_seen);
    end
    n_asserts++;
    if (sclk_act !== 1'b0 || frame_cyc !== 0 || err_stray !== 0) begin
      n_fail++;
      $display("FAIL err_quiet: got s%b f%0d x%0d want 0 0 0",
               sclk_act, frame_cyc, err_stray);
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < NR; i++) bank[i] = 8'($urandom);
    run_xfer(2'd0, 3'd2, -1, -1, 20);
    n_asserts++;
    if ({rs_sclk, rs_sframe, rs_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_outs: got %b%b%b want 000",
               rs_sclk, rs_sframe, rs_busy);
    end
    n_asserts++;
    if (done_n !== 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d want 0", done_n);
    end
    run_xfer(2'd1, 3'd1, -1, -1, -1);
    n_asserts++;
    if (cap_bits !== {24'd0, bank[1]} || done_n !== 1 ||
        err_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next: got %h d%0d want %h d1",
               cap_bits, done_n, bank[1]);
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic [2:0] n;
    int en;
    logic [31:0] exp;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NR; i++) bank[i] = 8'($urandom);
      a = 2'($urandom_range(0, NR - 1));
      n = 3'($urandom_range(0, NR + 1));
      en = (int'(n) > NR) ? 0 : int'(n);
      exp = model_stream(int'(a), en);
      run_xfer(a, n, -1, -1, -1);
      n_asserts++;
      if (cap_bits !== exp || cap_n !== 8 * en) begin
        n_fail++;
        $display("FAIL rand_bits[%0d]: got %h/%0d want %h/%0d",
                 it, cap_bits, cap_n, exp, 8 * en);
      end
      n_asserts++;
      if (done_n !== 1 || done_cyc !== 1 + PER_REG * en ||
          err_seen !== (int'(n) > NR) ||
          frame_cyc !== PER_REG * en) begin
        n_fail++;
        $display("FAIL rand_done[%0d]: got %0d@%0d e%b f%0d",
                 it, done_n, done_cyc, err_seen, frame_cyc);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    for (int i = 0; i < NR; i++) bank[i] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_busy_ignore();
    test_zero_and_err();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end
endmodule
